// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: load/store sequencing, byte-lane steering and MEM/WB register
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of reaching memory.
module mem_stage #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [WORD_SIZE-1:0] result,
    input  logic [WORD_SIZE-1:0] save_data,
    input  logic [REG_SEL-1:0]   rd,
    input  logic [1:0]           data_size,
    input  logic                 data_sign,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 reg_write,
    output logic                 stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    output logic [3:0]           dmem_wstrb,
    output logic [WORD_SIZE-1:0] dmem_wdata,
    input  logic                 dmem_ready,
    input  logic                 dmem_rvalid,
    input  logic [WORD_SIZE-1:0] dmem_rdata,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REG_SEL-1:0]   wb_rd,
    output logic [WORD_SIZE-1:0] wb_data,
`ifdef MISALIGN_TRAP_EN
    output logic                 misalign_exc,
    output logic [ADDR_SIZE-1:0] exc_addr,
`endif
    output logic [WORD_SIZE-1:0] mem_forward
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

    state_t                 state_q, state_d;
    logic                   we_q, sign_q, reg_write_q;
    logic [1:0]             size_q, lane_q;
    logic [REG_SEL-1:0]     rd_q;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [3:0]             wstrb_q;
    logic [WORD_SIZE-1:0]   wdata_q;

    logic                   mem_op, accept, trap;
    logic [1:0]             lane_d;
    logic [3:0]             wstrb_d;
    logic [WORD_SIZE-1:0]   wdata_d, shifted, load_data;
    logic [ADDR_SIZE-1:0]   addr_full;

    assign mem_op    = mem_read | mem_write;
    assign accept    = (state_q == IDLE) && ex_valid;
    assign addr_full = ADDR_SIZE'(result);

`ifdef MISALIGN_TRAP_EN
    assign trap = accept && mem_op &&
                  (((data_size == 2'b01) && result[0]) ||
                   (data_size[1] && (result[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        lane_d  = 2'b00;
        wstrb_d = 4'b1111;
        wdata_d = save_data;
        case (data_size)
            2'b00: begin
                lane_d  = result[1:0];
                wstrb_d = 4'b0001 << lane_d;
                wdata_d = {(WORD_SIZE/8){save_data[7:0]}};
            end
            2'b01: begin
                lane_d  = {result[1], 1'b0};
                wstrb_d = 4'b0011 << lane_d;
                wdata_d = {(WORD_SIZE/16){save_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Word accesses always have lane 0, so the shifted value is the raw word.
    assign shifted = dmem_rdata >> {lane_q, 3'b000};

    always_comb begin
        load_data = shifted;
        case (size_q)
            2'b00:   load_data = {{(WORD_SIZE-8){sign_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{(WORD_SIZE-16){sign_q & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && mem_op && !trap) state_d = REQ;
            REQ:     if (dmem_ready) state_d = we_q ? IDLE : WAIT_RD;
            WAIT_RD: if (dmem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            sign_q       <= 1'b0;
            reg_write_q  <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            rd_q         <= '0;
            addr_q       <= '0;
            wstrb_q      <= 4'b0000;
            wdata_q      <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_exc <= 1'b0;
            exc_addr     <= '0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_exc <= 1'b0;
`endif
            case (state_q)
                IDLE: if (ex_valid) begin
                    if (trap) begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= 1'b0;
                        wb_rd        <= rd;
`ifdef MISALIGN_TRAP_EN
                        misalign_exc <= 1'b1;
                        exc_addr     <= addr_full;
`endif
                    end else if (!mem_op) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= result;
                        wb_rd        <= rd;
                        wb_reg_write <= reg_write;
                    end else begin
                        we_q        <= mem_write;
                        sign_q      <= data_sign;
                        reg_write_q <= reg_write;
                        size_q      <= data_size;
                        lane_q      <= lane_d;
                        rd_q        <= rd;
                        addr_q      <= {addr_full[ADDR_SIZE-1:2], 2'b00};
                        wstrb_q     <= wstrb_d;
                        wdata_q     <= wdata_d;
                    end
                end
                REQ: if (dmem_ready && we_q) begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= 1'b0;
                    wb_rd        <= rd_q;
                end
                WAIT_RD: if (dmem_rvalid) begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= reg_write_q;
                    wb_rd        <= rd_q;
                    wb_data      <= load_data;
                end
                default: ;
            endcase
        end
    end

    assign stall       = (state_q != IDLE);
    assign dmem_req    = (state_q == REQ);
    assign dmem_we     = dmem_req & we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wstrb  = wstrb_q;
    assign dmem_wdata  = wdata_q;
    assign mem_forward = wb_data;

endmodule
